simple_dma_controller: RTL and testbench

Word-oriented DMA engine between `simple_dma_device` and the openMSP430 DMA memory port. It accepts a start address, word count and direction from the device over the `dma_rqst`/`dev_ack`/`dma_ack`/`dma_end_flag` handshake. It then performs one memory access per word: memory→device for read, device→memory for write. It signals completion or error back to the device.

---
 rtl/simple_dma_controller_pkg.sv | 21 ++
 rtl/simple_dma_controller.sv | 168 ++++++++++++++++
 tb/tb_simple_dma_controller.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_dma_controller_pkg.sv
// Shared definitions for the simple DMA controller: FSM states,
// memory byte-enable codes and the direction encoding used by the device.
package simple_dma_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_DEV = 3'd1,
    ST_LATCH    = 3'd2,
    ST_ACCESS   = 3'd3,
    ST_RDATA    = 3'd4,
    ST_ACK      = 3'd5,
    ST_DONE     = 3'd6
  } dma_state_e;

  localparam logic [1:0] DMA_WE_WORD = 2'b11;
  localparam logic [1:0] DMA_WE_NONE = 2'b00;

  // Direction as presented on dma_rd_wr: 1 = memory -> device.
  localparam logic DIR_READ = 1'b1;

endpackage

// File: rtl/simple_dma_controller.sv
// Word-oriented DMA engine between a simple DMA device and the CPU's
// DMA memory port. One memory access per word, with a per-word device
// handshake; all outputs are registered or decoded from the state.
module simple_dma_controller
  import simple_dma_controller_pkg::*;
#(
  parameter logic PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_rqst,
  input  logic        dma_rd_wr,
  input  logic [15:0] dma_start_address,
  input  logic [15:0] dma_num_words,
  input  logic        dev_ack,
  input  logic [15:0] dev_out,
  output logic [15:0] dev_in,
  output logic        dma_ack,
  output logic        dma_end_flag,
  output logic        dma_error,
  output logic [14:0] dma_addr,
  output logic [15:0] dma_din,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic        dma_priority,
  input  logic [15:0] dma_dout,
  input  logic        dma_ready,
  input  logic        dma_resp
);

  dma_state_e  state_reg;
  dma_state_e  state_next;
  logic [14:0] addr_reg;
  logic [15:0] count_reg;
  logic [15:0] data_reg;
  logic        dir_reg;
  logic        error_reg;
  logic [15:0] count_dec;
  logic        unused_addr_lsb;

  // The start address is a byte address; only the word part matters.
  assign unused_addr_lsb = dma_start_address[0];
  assign count_dec       = count_reg - 16'd1;

  // State register; reset may strike mid-access and must abandon it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode. Dropping dma_rqst only aborts while waiting on the
  // device; once a memory access is issued the word runs through ACK.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (dma_rqst) begin
          state_next = (dma_num_words == 16'd0) ? ST_DONE : ST_WAIT_DEV;
        end
      end
      ST_WAIT_DEV: begin
        if (!dma_rqst) begin
          state_next = ST_IDLE;
        end else if (dev_ack) begin
          state_next = (dir_reg == DIR_READ) ? ST_ACCESS : ST_LATCH;
        end
      end
      ST_LATCH: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (dma_ready) begin
          if (dir_reg == DIR_READ) begin
            state_next = ST_RDATA;
          end else if (dma_resp) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_ACK;
          end
        end
      end
      ST_RDATA: begin
        state_next = dma_resp ? ST_DONE : ST_ACK;
      end
      ST_ACK: begin
        if (count_dec == 16'd0) begin
          state_next = ST_DONE;
        end else if (!dma_rqst) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT_DEV;
        end
      end
      ST_DONE: begin
        if (!dma_rqst) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Transfer bookkeeping: address/count/direction, data buffer, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg  <= '0;
      count_reg <= '0;
      data_reg  <= '0;
      dir_reg   <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (dma_rqst) begin
            addr_reg  <= dma_start_address[15:1];
            count_reg <= dma_num_words;
            dir_reg   <= dma_rd_wr;
            error_reg <= 1'b0;
          end
        end
        ST_LATCH: begin
          data_reg <= dev_out;
        end
        ST_ACCESS: begin
          if (dma_ready && (dir_reg != DIR_READ) && dma_resp) begin
            error_reg <= 1'b1;
          end
        end
        ST_RDATA: begin
          data_reg <= dma_dout;
          if (dma_resp) begin
            error_reg <= 1'b1;
          end
        end
        ST_ACK: begin
          addr_reg  <= addr_reg + 15'd1;
          count_reg <= count_dec;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from state; the memory bus is quiet outside ACCESS.
  always_comb begin
    dma_en       = (state_reg == ST_ACCESS);
    dma_we       = DMA_WE_NONE;
    dma_addr     = '0;
    dma_din      = '0;
    if (state_reg == ST_ACCESS) begin
      dma_we   = (dir_reg == DIR_READ) ? DMA_WE_NONE : DMA_WE_WORD;
      dma_addr = addr_reg;
      dma_din  = data_reg;
    end
    dma_ack      = (state_reg == ST_ACK);
    dma_end_flag = (state_reg == ST_DONE);
    dma_error    = error_reg;
    dev_in       = data_reg;
    dma_priority = PRIORITY;
  end

endmodule

// File: tb/tb_simple_dma_controller.sv
// Bench for simple_dma_controller: the bench plays both the device and the
// memory, and checks every access/ack against a word-level model of the
// transfer (address sequence, data, number of words, error, timing).
module tb_simple_dma_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dma_rqst = 1'b0;
  logic        dma_rd_wr = 1'b0;
  logic [15:0] dma_start_address = '0;
  logic [15:0] dma_num_words = '0;
  logic        dev_ack = 1'b0;
  logic [15:0] dev_out = '0;
  logic [15:0] dev_in;
  logic        dma_ack;
  logic        dma_end_flag;
  logic        dma_error;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic        dma_priority;
  logic [15:0] dma_dout = '0;
  logic        dma_ready = 1'b0;
  logic        dma_resp = 1'b0;

  simple_dma_controller #(.PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset), .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
    .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
    .dev_ack(dev_ack), .dev_out(dev_out), .dev_in(dev_in), .dma_ack(dma_ack),
    .dma_end_flag(dma_end_flag), .dma_error(dma_error), .dma_addr(dma_addr),
    .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we),
    .dma_priority(dma_priority), .dma_dout(dma_dout), .dma_ready(dma_ready),
    .dma_resp(dma_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory image and device write data.
  logic [15:0] mem   [0:32767];
  logic [15:0] wdata [0:63];

  // Model state of the current transfer.
  logic [14:0] base;
  bit          wr_dir;
  int          acc_k, ack_n, cyc, first_ack, last_ack, end_cyc;
  int          err_word, ready_pct, devack_pct;
  bit          prev_ack, pend_rd, pend_err;
  logic [14:0] pend_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of environment: observe at the falling edge, then drive the
  // memory and device responses for the next rising edge.
  task automatic step();
    logic [14:0] a;
    bit          e;
    @(negedge clk);
    cyc++;
    if (dma_ack) begin
      chk("ack_not_back_to_back", 32'(prev_ack), 32'd0);
      if (!wr_dir) begin
        a = base + 15'(ack_n);
        chk("dev_in_read", 32'(dev_in), 32'(mem[a]));
      end
      ack_n++;
      if (first_ack < 0) first_ack = cyc;
      last_ack = cyc;
    end
    prev_ack = dma_ack;
    if (dma_end_flag && end_cyc < 0) end_cyc = cyc;
    dma_ready = 1'b0;
    dma_resp  = 1'b0;
    if (pend_rd) begin
      dma_dout = mem[pend_addr];
      dma_resp = pend_err;
      pend_rd  = 1'b0;
    end else begin
      dma_dout = 16'($urandom);
    end
    if (dma_en) begin
      a = base + 15'(acc_k);
      chk("dma_addr", 32'(dma_addr), 32'(a));
      chk("dma_we", 32'(dma_we), wr_dir ? 32'h3 : 32'h0);
      if (wr_dir) chk("dma_din", 32'(dma_din), 32'(wdata[acc_k & 63]));
      if ($urandom_range(99) < ready_pct) begin
        e = (acc_k == err_word);
        dma_ready = 1'b1;
        if (wr_dir) begin
          dma_resp = e;
          if (!e) mem[a] = wdata[acc_k & 63];
        end else begin
          pend_rd   = 1'b1;
          pend_addr = a;
          pend_err  = e;
        end
        acc_k++;
      end
    end
    dev_ack = ($urandom_range(99) < devack_pct);
    dev_out = wdata[ack_n & 63];
  endtask

  task automatic begin_xfer(input logic [15:0] start, input int n, input bit dir,
                            input int rpct, input int dpct, input int errw);
    base = start[15:1];
    wr_dir = !dir;
    acc_k = 0; ack_n = 0; cyc = 0;
    first_ack = -1; last_ack = -1; end_cyc = -1;
    prev_ack = 1'b0; pend_rd = 1'b0;
    err_word = errw; ready_pct = rpct; devack_pct = dpct;
    for (int i = 0; i < 64; i++) wdata[i] = 16'($urandom);
    dma_rqst = 1'b1;
    dma_start_address = start;
    dma_num_words = 16'(n);
    dma_rd_wr = dir;
    dev_ack = ($urandom_range(99) < dpct);
    dev_out = wdata[0];
  endtask

  task automatic finish_xfer(input int n, input int errw);
    bit err_hit;
    int exp_acc, exp_ack;
    bit fast;
    err_hit = (errw >= 0) && (errw < n);
    exp_acc = err_hit ? errw + 1 : n;
    exp_ack = err_hit ? errw : n;
    fast = (ready_pct == 100) && (devack_pct == 100);
    step();
    chk("error_cleared_at_start", 32'(dma_error), 32'd0);
    while (end_cyc < 0 && cyc < 600) step();
    chk("end_reached", 32'(end_cyc >= 0), 32'd1);
    chk("accesses", 32'(acc_k), 32'(exp_acc));
    chk("acks", 32'(ack_n), 32'(exp_ack));
    chk("dma_error", 32'(dma_error), 32'(err_hit));
    if (!err_hit && n > 0) chk("end_after_last_ack", 32'(end_cyc), 32'(last_ack + 1));
    if (fast && n == 0) chk("zero_word_end_latency", 32'(end_cyc), 32'd1);
    if (fast && n > 0 && !err_hit) begin
      chk("first_ack_latency", 32'(first_ack), 32'd4);
      chk("end_latency", 32'(end_cyc), 32'(4 * n + 1));
    end
    step();
    chk("end_flag_held", 32'(dma_end_flag), 32'd1);
    dma_rqst = 1'b0;
    step();
    chk("end_flag_released", 32'(dma_end_flag), 32'd0);
    chk("error_sticky", 32'(dma_error), 32'(err_hit));
    $display("xfer start=%h n=%0d %s err_word=%0d acks=%0d accesses=%0d end_cyc=%0d",
             dma_start_address, n, wr_dir ? "write" : "read", errw, ack_n, acc_k, end_cyc);
  endtask

  task automatic run_xfer(input logic [15:0] start, input int n, input bit dir,
                          input int rpct, input int dpct, input int errw);
    begin_xfer(start, n, dir, rpct, dpct, errw);
    finish_xfer(n, errw);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(dma_en), 32'd0);
    chk({tag, "_we"}, 32'(dma_we), 32'd0);
    chk({tag, "_addr"}, 32'(dma_addr), 32'd0);
    chk({tag, "_din"}, 32'(dma_din), 32'd0);
    chk({tag, "_ack"}, 32'(dma_ack), 32'd0);
    chk({tag, "_end"}, 32'(dma_end_flag), 32'd0);
    chk({tag, "_error"}, 32'(dma_error), 32'd0);
    chk({tag, "_dev_in"}, 32'(dev_in), 32'd0);
    chk({tag, "_priority"}, 32'(dma_priority), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, errw;
    bit seen_end;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 3; i++) mem[16'h0100 + i] = 16'hA000 + 16'(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Read 3 words from 0x0200, full speed
    run_xfer(16'h0200, 3, 1'b1, 100, 100, -1);

    // Write 2 words to 0x0300 with fixed device data
    begin_xfer(16'h0300, 2, 1'b0, 100, 100, -1);
    wdata[0] = 16'h1111; wdata[1] = 16'h2222; dev_out = wdata[0];
    finish_xfer(2, -1);
    chk("write_mem0", 32'(mem[15'h180]), 32'h1111);
    chk("write_mem1", 32'(mem[15'h181]), 32'h2222);

    // Zero words
    run_xfer(16'h0400, 0, 1'b1, 100, 100, -1);

    // Stall and address wrap
    run_xfer(16'hFFFE, 2, 1'b1, 25, 100, -1);
    run_xfer(16'hFFFF, 2, 1'b0, 25, 60, -1);

    // Bus error on word 2 of 4, both directions; next start clears the error
    run_xfer(16'h0800, 4, 1'b1, 100, 100, 1);
    run_xfer(16'h0900, 4, 1'b0, 70, 100, 1);
    run_xfer(16'h0A00, 1, 1'b1, 100, 100, -1);

    // Randomised transfers
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(6);
      errw = ($urandom_range(3) == 0) ? int'($urandom_range(5)) : -1;
      run_xfer(16'($urandom), n, 1'($urandom), $urandom_range(30, 100),
               $urandom_range(30, 100), errw);
    end

    // Request dropped while waiting for the device: no end flag
    begin_xfer(16'h0400, 3, 1'b1, 100, 0, -1);
    repeat (4) step();
    chk("waitdev_no_access", 32'(acc_k), 32'd0);
    dma_rqst = 1'b0;
    seen_end = 1'b0;
    repeat (4) begin step(); seen_end |= dma_end_flag; end
    chk("waitdev_abort_no_end", 32'(seen_end), 32'd0);
    $display("abort in WAIT_DEV accesses=%0d end_seen=%0d", acc_k, seen_end);

    // Request dropped during an access: word completes, then back to idle
    begin_xfer(16'h0200, 3, 1'b1, 100, 100, -1);
    for (int k = 0; k < 20 && acc_k == 0; k++) step();
    dma_rqst = 1'b0;
    seen_end = 1'b0;
    repeat (8) begin step(); seen_end |= dma_end_flag; end
    chk("access_abort_acks", 32'(ack_n), 32'd1);
    chk("access_abort_accesses", 32'(acc_k), 32'd1);
    chk("access_abort_no_end", 32'(seen_end), 32'd0);
    $display("abort in ACCESS acks=%0d accesses=%0d end_seen=%0d", ack_n, acc_k, seen_end);

    // Reset in the middle of a stalled write access
    run_xfer(16'h0200, 1, 1'b1, 100, 100, -1);
    begin_xfer(16'h0600, 2, 1'b0, 0, 100, -1);
    wdata[0] = 16'h5A5A; dev_out = wdata[0];
    for (int k = 0; k < 20 && !dma_en; k++) step();
    chk("pre_reset_in_access", 32'(dma_en), 32'd1);
    #2 reset = 1'b1;
    #1 chk_all_zero("mid_access_reset");
    dma_rqst = 1'b0; dma_ready = 1'b0; pend_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("reset during ACCESS en=%0d dev_in=%h", dma_en, dev_in);
    run_xfer(16'h0200, 3, 1'b1, 100, 100, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
